// File: rtl/adder_share_pkg.sv
// Shared types, widths and helpers for the time-shared adder controller.
package adder_share_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Round-robin pointer moves to the slot just after the last served requester.
  function automatic int rr_next_ptr(input int id, input int num_req);
    return (id + 1) % num_req;
  endfunction

endpackage

// File: rtl/adder_share_if.sv
// Request/response bundle between the requester cluster and the adder controller.
interface adder_share_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]                         req_valid_in;
  logic [adder_share_pkg::DATA_W*NUM_REQ-1:0] req_a_in;
  logic [adder_share_pkg::DATA_W*NUM_REQ-1:0] req_b_in;
  logic [NUM_REQ-1:0]                         req_ready_out;
  logic                                       rsp_valid_out;
  logic                                       rsp_ready_in;
  logic [adder_share_pkg::DATA_W-1:0]         rsp_sum_out;
  logic                                       rsp_carry_out;
  logic [ID_W-1:0]                            rsp_id_out;
  logic                                       busy_out;

  // Controller side.
  modport slave (
    input  req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_sum_out, rsp_carry_out,
           rsp_id_out, busy_out
  );

  // Requester / consumer side.
  modport master (
    output req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_sum_out, rsp_carry_out,
           rsp_id_out, busy_out
  );

endinterface

// File: rtl/adder_8bit.sv
// Plain unsigned 8-bit adder with carry out; the one shared datapath instance.
module adder_8bit
  import adder_share_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  // Walk the requesters starting at ptr and take the first one that is asking.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one 8-bit adder among NUM_REQ requesters with round-robin grant
// and a valid/ready response channel carrying sum, carry and owner ID.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  adder_share_if.slave  bus
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_vld;
  logic                accept;
  logic                rsp_fire;
  logic [DATA_W-1:0]   add_sum;
  logic                add_carry;
  logic [DATA_W-1:0]   sum_q;
  logic                carry_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_valid_q;
  logic                busy_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid_in),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  adder_8bit u_add (
    .a     (a_q),
    .b     (b_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign accept   = (state_q == IDLE) && grant_vld;
  assign rsp_fire = (state_q == RESP) && bus.rsp_ready_in;

  // Grant strobe is only offered in IDLE and is suppressed while reset is held.
  assign bus.req_ready_out = ((state_q == IDLE) && rst_n_in) ? grant : '0;
  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_sum_out   = sum_q;
  assign bus.rsp_carry_out = carry_q;
  assign bus.rsp_id_out    = rsp_id_q;
  assign bus.busy_out      = busy_q;

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State, rotation pointer and registered status flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      if (rsp_fire) begin
        ptr_q <= ID_W'(rr_next_ptr(int'(id_q), NUM_REQ));
      end
    end
  end

  // Operand capture happens only on the grant cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else if (accept) begin
      a_q  <= bus.req_a_in[DATA_W*int'(grant_idx) +: DATA_W];
      b_q  <= bus.req_b_in[DATA_W*int'(grant_idx) +: DATA_W];
      id_q <= grant_idx;
    end
  end

  // Adder result is registered in EXEC and held through RESP.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_q    <= '0;
      carry_q  <= 1'b0;
      rsp_id_q <= '0;
    end else if (state_q == EXEC) begin
      sum_q    <= add_sum;
      carry_q  <= add_carry;
      rsp_id_q <= id_q;
    end
  end

endmodule
